// File: rtl/multi_led_sequencer.sv
// multi_led_sequencer: NUM_CH independent LED channels (OFF / ON / BLINK / BURST)
// sharing one free-running prescaler tick. All outputs come straight from flops.

module multi_led_seq_ch #(
   parameter int HALF_W = 12,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              we,
   input  logic [1:0]        mode,
   input  logic [HALF_W-1:0] half,
   input  logic [CNT_W-1:0]  count,
   output logic              led,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3} mode_e;

   mode_e             mode_q, mode_d;
   logic [HALF_W-1:0] half_q, half_d;
   logic [HALF_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              led_d, busy_d, done_d, burst_end;

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q  <= M_OFF;
         half_q  <= HALF_W'(1);
         phase_q <= '0;
         rem_q   <= '0;
         led     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         half_q  <= half_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         led     <= led_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // A write always beats a same-cycle tick; rem_q is >=1 whenever BURST is live.
   always_comb begin
      mode_d    = mode_q;
      half_d    = half_q;
      phase_d   = phase_q;
      rem_d     = rem_q;
      led_d     = led;
      burst_end = 1'b0;
      if (we) begin
         mode_d  = mode_e'(mode);
         half_d  = (half == '0) ? HALF_W'(1) : half;
         phase_d = '0;
         rem_d   = count;
         led_d   = (mode != 2'd0);
         if (mode == 2'd3 && count == '0) begin
            mode_d    = M_OFF;
            led_d     = 1'b0;
            burst_end = 1'b1;
         end
      end else if (tick && (mode_q == M_BLINK || mode_q == M_BURST)) begin
         if (phase_q == half_q - HALF_W'(1)) begin
            phase_d = '0;
            led_d   = ~led;
            if (mode_q == M_BURST && led) begin
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  mode_d    = M_OFF;
                  led_d     = 1'b0;
                  burst_end = 1'b1;
               end
            end
         end else begin
            phase_d = phase_q + HALF_W'(1);
         end
      end
   end

   always_comb begin
      busy_d = (mode_d == M_BLINK) || (mode_d == M_BURST);
      done_d = burst_end;
   end
endmodule

module multi_led_sequencer #(
   parameter int CLK_FREQ_HZ = 48_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int NUM_CH      = 4,
   parameter int HALF_W      = 12,
   parameter int CNT_W       = 8
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             cfg_we,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   cfg_ch,
   input  logic [1:0]                                       cfg_mode,
   input  logic [HALF_W-1:0]                                cfg_half,
   input  logic [CNT_W-1:0]                                 cfg_count,
   output logic [NUM_CH-1:0]                                led,
   output logic [NUM_CH-1:0]                                busy,
   output logic [NUM_CH-1:0]                                done,
   output logic                                             tick
);
   localparam int PRESC = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW    = $clog2(PRESC);

   logic [PW-1:0] presc_q, presc_d;

   assign presc_d = (presc_q == PW'(PRESC - 1)) ? '0 : presc_q + PW'(1);

   // tick is registered from the look-ahead count so it is high exactly while presc_q == PRESC-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         tick    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick    <= (presc_d == PW'(PRESC - 1));
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic we_i;
      // Equality against an in-range index also drops writes to cfg_ch >= NUM_CH.
      assign we_i = cfg_we && (32'(cfg_ch) == 32'(i));
      multi_led_seq_ch #(.HALF_W(HALF_W), .CNT_W(CNT_W)) u_ch (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .we    (we_i),
         .mode  (cfg_mode),
         .half  (cfg_half),
         .count (cfg_count),
         .led   (led[i]),
         .busy  (busy[i]),
         .done  (done[i])
      );
   end
endmodule
